// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the push-button conditioning stage.
//   - btn_state_t : per-channel FSM state encoding
//   - DB_W        : width of the saturating debounce counter
//   - DEF_*       : default cycle counts and timer width
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_t;

  localparam int DB_W = 20;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_HOLD_CYCLES     = 5000000;
  localparam int DEF_REPEAT_CYCLES   = 2000000;
  localparam int DEF_TMR_W           = 24;

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- 2-flop synchroniser, saturating
// debounce counter, state machine and (optionally) hold/repeat timer.
// Configuration macro: BTN_AUTOREPEAT_EN adds the HELD-state timer and
// repeat requests; without it HELD only waits for the release.
// Ports:
//   clk        in  : rising-edge clock
//   rst_n      in  : asynchronous active-low reset
//   btn        in  : raw asynchronous button level, active-high
//   press_req  out : 1-cycle request on an accepted press
//   repeat_req out : 1-cycle auto-repeat request while held
//   held       out : debounced pressed state (HELD or RELEASE_DB)
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int TMR_W         = DEF_TMR_W
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_req,
  output logic repeat_req,
  output logic held
);

  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYCLES);
  logic [TMR_W-1:0] timer;
`endif

  logic            sync_a;
  logic            sync_b;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_inc;
  btn_state_t      state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Saturate instead of wrapping so a very long stable level cannot
  // roll the counter back through the limit.
  assign db_inc = (db_cnt == '1) ? db_cnt : db_cnt + DB_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      db_cnt     <= '0;
      press_req  <= 1'b0;
      repeat_req <= 1'b0;
      held       <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      timer      <= '0;
`endif
    end else begin
      press_req  <= 1'b0;
      repeat_req <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_b) begin
            db_cnt <= '0;
            state  <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!sync_b) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_inc;
            if (db_inc == DB_LIMIT) begin
              press_req <= 1'b1;
              held      <= 1'b1;
              state     <= HELD;
`ifdef BTN_AUTOREPEAT_EN
              timer     <= HOLD_LOAD;
`endif
            end
          end
        end
        HELD: begin
          if (!sync_b) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
`ifdef BTN_AUTOREPEAT_EN
          // A timer value of 1 means this decrement reaches zero.
          else if (timer == TMR_W'(1)) begin
            repeat_req <= 1'b1;
            timer      <= REPEAT_LOAD;
          end else begin
            timer <= timer - TMR_W'(1);
          end
`endif
        end
        RELEASE_DB: begin
          // A bounce back high resumes HELD with the timer frozen.
          if (sync_b) begin
            state <= HELD;
          end else begin
            db_cnt <= db_inc;
            if (db_inc == DB_LIMIT) begin
              held  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the increment/decrement push buttons into
// clean single-cycle step pulses for the 0-9 duty-level counter, and
// guarantees the counter never sees both steps in the same cycle.
// Configuration macro: BTN_AUTOREPEAT_EN enables auto-repeat while held.
// Ports:
//   clk        in      : rising-edge clock
//   rst_n      in      : asynchronous active-low reset
//   incr_btn_i in      : raw increment button level, active-high
//   decr_btn_i in      : raw decrement button level, active-high
//   incr_o     out     : registered 1-cycle increment pulse
//   decr_o     out     : registered 1-cycle decrement pulse
//   held_o     out [2] : debounced pressed state, bit0 incr, bit1 decr
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int TMR_W           = DEF_TMR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       incr_btn_i,
  input  logic       decr_btn_i,
  output logic       incr_o,
  output logic       decr_o,
  output logic [1:0] held_o
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << DB_W) - 1 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || TMR_W < 1 || TMR_W > 31 ||
      (longint'(HOLD_CYCLES) >> TMR_W) != 0 ||
      (longint'(REPEAT_CYCLES) >> TMR_W) != 0) begin : g_bad_params
    $error("btn_conditioner: illegal parameter combination");
  end

  logic [1:0] press_req;
  logic [1:0] repeat_req;
  logic [1:0] held;
  logic [1:0] req;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .TMR_W          (TMR_W)
`endif
  ) u_incr (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (incr_btn_i),
    .press_req (press_req[0]),
    .repeat_req(repeat_req[0]),
    .held      (held[0])
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .TMR_W          (TMR_W)
`endif
  ) u_decr (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (decr_btn_i),
    .press_req (press_req[1]),
    .repeat_req(repeat_req[1]),
    .held      (held[1])
  );

  // With both buttons down, repeats are suppressed so the level does not
  // run away in either direction; first presses still pass.
  assign req = press_req | (repeat_req & {2{~&held}});

  // Coincident requests cancel each other rather than picking a winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incr_o <= 1'b0;
      decr_o <= 1'b0;
    end else begin
      incr_o <= req[0] & ~req[1];
      decr_o <= req[1] & ~req[0];
    end
  end

  assign held_o = held;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: self-checking bench for btn_conditioner with
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8. Expected pulses are
// queued as (cycle, channel) when stimulus is planned and popped whenever
// the DUT pulses. Expectations follow BTN_AUTOREPEAT_EN when defined.
module tb_btn_conditioner;

  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 8;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       incr_btn = 1'b0;
  logic       decr_btn = 1'b0;
  logic       incr_o;
  logic       decr_o;
  logic [1:0] held_o;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int base;
  int base2;
  int obs;
  int expv;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HLD),
    .REPEAT_CYCLES  (REP),
    .TMR_W          (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .incr_btn_i(incr_btn),
    .decr_btn_i(decr_btn),
    .incr_o    (incr_o),
    .decr_o    (decr_o),
    .held_o    (held_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Encodes an expected pulse: channel 1 = incr, 2 = decr.
  function automatic int ev(input int c, input int ch);
    return c * 4 + ch;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (incr_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_incr: got %b, required 0", incr_o);
    end
    tests++;
    if (decr_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_decr: got %b, required 0", decr_o);
    end
    tests++;
    if (held_o !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_held: got %b, required 00", held_o);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (held_o !== 2'b00 || incr_o !== 1'b0 || decr_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got held=%b incr=%b decr=%b, required 00/0/0",
               held_o, incr_o, decr_o);
    end
  endtask

  task automatic test_clean_press();
    @(negedge clk);
    base = cyc + 1;
    exp_q.push_back(ev(base + LAT, 1));
    for (int i = 0; i < 25; i++) begin
      incr_btn = (i < 10);
      @(negedge clk);
      if (incr_o || decr_o) begin
        obs = cyc * 4 + int'({decr_o, incr_o});
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL clean_pulse: got ch=%0d at cycle %0d, required none", obs % 4, cyc - base);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL clean_pulse: got ch=%0d cycle %0d, required ch=%0d cycle %0d",
                     obs % 4, obs / 4 - base, expv % 4, expv / 4 - base);
          end
        end
      end
      if (i == 5 || i == 6 || i == 15 || i == 16) begin
        tests++;
        if (held_o[0] !== (i == 6 || i == 15)) begin
          fails++;
          $display("[TB] FAIL clean_held: cycle %0d got %b, required %b", i, held_o[0], (i == 6 || i == 15));
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL clean_missing: got %0d pulses left unseen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_bouncy_press();
    @(negedge clk);
    base = cyc + 1;
    // Final rising edge is at relative edge 7.
    exp_q.push_back(ev(base + 7 + LAT, 2));
    for (int i = 0; i < 35; i++) begin
      decr_btn = (i < 22) && (i != 2) && (i != 6);
      @(negedge clk);
      if (incr_o || decr_o) begin
        obs = cyc * 4 + int'({decr_o, incr_o});
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL bouncy_pulse: got ch=%0d at cycle %0d, required none", obs % 4, cyc - base);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL bouncy_pulse: got ch=%0d cycle %0d, required ch=%0d cycle %0d",
                     obs % 4, obs / 4 - base, expv % 4, expv / 4 - base);
          end
        end
      end
      if (i == 8 || i == 12 || i == 13) begin
        tests++;
        if (held_o[1] !== (i == 13)) begin
          fails++;
          $display("[TB] FAIL bouncy_held: cycle %0d got %b, required %b", i, held_o[1], (i == 13));
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL bouncy_missing: got %0d pulses left unseen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_hold_repeat();
    @(negedge clk);
    base = cyc + 1;
    exp_q.push_back(ev(base + LAT, 1));
`ifdef BTN_AUTOREPEAT_EN
    for (int p = LAT + HLD; p <= 59; p += REP) exp_q.push_back(ev(base + p, 1));
`endif
    for (int i = 0; i < 73; i++) begin
      incr_btn = (i < 60);
      @(negedge clk);
      if (incr_o || decr_o) begin
        obs = cyc * 4 + int'({decr_o, incr_o});
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL hold_pulse: got ch=%0d at cycle %0d, required none", obs % 4, cyc - base);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL hold_pulse: got ch=%0d cycle %0d, required ch=%0d cycle %0d",
                     obs % 4, obs / 4 - base, expv % 4, expv / 4 - base);
          end
        end
      end
      if (i == 65 || i == 66) begin
        tests++;
        if (held_o[0] !== (i == 65)) begin
          fails++;
          $display("[TB] FAIL hold_release: cycle %0d got %b, required %b", i, held_o[0], (i == 65));
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL hold_missing: got %0d pulses left unseen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    base = cyc + 1;
    for (int i = 0; i < 51; i++) begin
      incr_btn = (i < 40);
      decr_btn = (i < 40);
      @(negedge clk);
      if (incr_o || decr_o) begin
        obs = cyc * 4 + int'({decr_o, incr_o});
        tests++;
        fails++;
        $display("[TB] FAIL simul_pulse: got ch=%0d at cycle %0d, required none", obs % 4, cyc - base);
      end
      if (i == 10 || i == 30 || i == 48) begin
        tests++;
        if (held_o !== ((i == 48) ? 2'b00 : 2'b11)) begin
          fails++;
          $display("[TB] FAIL simul_held: cycle %0d got %b, required %b", i, held_o,
                   ((i == 48) ? 2'b00 : 2'b11));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // decr pressed while incr is held: its first press still passes, but
    // incr repeats are held off until decr is fully released.
    @(negedge clk);
    base = cyc + 1;
    exp_q.push_back(ev(base + LAT, 1));
    exp_q.push_back(ev(base + 10 + LAT, 2));
`ifdef BTN_AUTOREPEAT_EN
    exp_q.push_back(ev(base + LAT + HLD + 2 * REP, 1));
`endif
    for (int i = 0; i < 56; i++) begin
      incr_btn = (i < 45);
      decr_btn = (i >= 10) && (i < 30);
      @(negedge clk);
      if (incr_o || decr_o) begin
        obs = cyc * 4 + int'({decr_o, incr_o});
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL b2b_pulse: got ch=%0d at cycle %0d, required none", obs % 4, cyc - base);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL b2b_pulse: got ch=%0d cycle %0d, required ch=%0d cycle %0d",
                     obs % 4, obs / 4 - base, expv % 4, expv / 4 - base);
          end
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL b2b_missing: got %0d pulses left unseen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    base = cyc + 1;
    exp_q.push_back(ev(base + LAT, 1));
`ifdef BTN_AUTOREPEAT_EN
    exp_q.push_back(ev(base + LAT + HLD, 1));
`endif
    for (int i = 0; i < 56; i++) begin
      incr_btn = (i < 40);
      @(negedge clk);
      if (incr_o || decr_o) begin
        obs = cyc * 4 + int'({decr_o, incr_o});
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL rstmid_pulse: got ch=%0d at cycle %0d, required none", obs % 4, cyc - base);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL rstmid_pulse: got ch=%0d cycle %0d, required ch=%0d cycle %0d",
                     obs % 4, obs / 4 - base, expv % 4, expv / 4 - base);
          end
        end
      end
      if (i == LAT + HLD) begin
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (incr_o !== 1'b0 || decr_o !== 1'b0) begin
          fails++;
          $display("[TB] FAIL rstmid_out: got incr=%b decr=%b, required 0/0", incr_o, decr_o);
        end
        tests++;
        if (held_o !== 2'b00) begin
          fails++;
          $display("[TB] FAIL rstmid_held: got %b, required 00", held_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base2 = cyc + 1;
        exp_q.push_back(ev(base2 + LAT, 1));
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL rstmid_missing: got %0d pulses left unseen, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_hold_repeat();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
